// File: rtl/serial_addsub_cmp_if.sv
// Handshake and result bundle for the bit-serial add/subtract/compare unit.
// The master drives the request; the slave drives status and results.
interface serial_addsub_cmp_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             cmp1;
  logic             cmp2;
  logic             cmp3;

  modport master (
    output start, op, a, b,
    input  busy, done, s, cout, ovf, cmp1, cmp2, cmp3
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, s, cout, ovf, cmp1, cmp2, cmp3
  );
endinterface

// File: rtl/serial_addsub_cmp.sv
// Bit-serial two's-complement adder/subtractor with signed compare flags.
// One full-adder cell per cycle, LSB first; results land together with the Done pulse.
module serial_addsub_cmp #(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_addsub_cmp_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sr_q, s_q;
  logic [CntW-1:0]  cnt_q;
  logic             op_q, carry_q;
  logic             busy_q, done_q, cout_q, ovf_q, cmp1_q, cmp2_q, cmp3_q;

  logic             a_bit, b_bit, fa_sum, fa_carry, last_bit;
  logic             ovf_n, zero_n, lt_n;
  logic [WIDTH-1:0] res_n;

  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q] ^ op_q;
    fa_sum   = a_bit ^ b_bit ^ carry_q;
    fa_carry = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
    last_bit = (cnt_q == CntW'(WIDTH - 1));
    // On the last bit the shift register still lacks the MSB; splice it in here.
    res_n    = {fa_sum, sr_q[WIDTH-1:1]};
    // carry_q is the carry into the MSB while the last bit is processed.
    ovf_n    = carry_q ^ fa_carry;
    zero_n   = (res_n == '0);
    lt_n     = res_n[WIDTH-1] ^ ovf_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cmp1_q  <= 1'b0;
      cmp2_q  <= 1'b0;
      cmp3_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            carry_q <= bus.op;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          sr_q    <= res_n;
          carry_q <= fa_carry;
          cnt_q   <= cnt_q + CntW'(1);
          if (last_bit) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= res_n;
            cout_q  <= fa_carry;
            ovf_q   <= ovf_n;
            cmp1_q  <= op_q & ~lt_n & ~zero_n;
            cmp2_q  <= op_q & zero_n;
            cmp3_q  <= op_q & lt_n;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.cmp1 = cmp1_q;
  assign bus.cmp2 = cmp2_q;
  assign bus.cmp3 = cmp3_q;
endmodule

// File: tb/tb_serial_addsub_cmp.sv
// Directed, table-driven bench for serial_addsub_cmp at WIDTH=4.
module tb_serial_addsub_cmp;
  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_addsub_cmp_if #(.WIDTH(4)) bus ();

  serial_addsub_cmp #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic [2:0] cmp;  // {cmp1, cmp2, cmp3}
  } vec_t;

  vec_t vecs[9];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cyc, busy_cyc;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] cmp_now();
    return {bus.cmp1, bus.cmp2, bus.cmp3};
  endfunction

  // Issue one operation and report the cycle of the Done pulse and Busy length.
  task automatic run_op(input logic op, input logic [3:0] a, input logic [3:0] b,
                        output int d_cyc, output int b_cyc);
    @(negedge clk);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    d_cyc = 0;
    b_cyc = 0;
    for (int k = 1; k <= 20 && d_cyc == 0; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = ~b;
      if (bus.busy) b_cyc++;
      if (bus.done) d_cyc = k;
    end
  endtask

  initial begin
    int         done_seen;
    int         first_done, second_done, prev_done, double_done;
    logic [3:0] s_first, s_second;
    logic [2:0] c_first, c_second;

    vecs[0] = '{1'b0, 4'd3,  4'd5,  4'b1000, 1'b0, 1'b1, 3'b000};
    vecs[1] = '{1'b1, 4'h8,  4'hB,  4'b1101, 1'b0, 1'b0, 3'b001};
    vecs[2] = '{1'b1, 4'd5,  4'hF,  4'b0110, 1'b0, 1'b0, 3'b100};
    vecs[3] = '{1'b1, 4'd2,  4'd2,  4'b0000, 1'b1, 1'b0, 3'b010};
    vecs[4] = '{1'b1, 4'd7,  4'h8,  4'b1111, 1'b0, 1'b1, 3'b100};
    vecs[5] = '{1'b0, 4'hF,  4'd1,  4'b0000, 1'b1, 1'b0, 3'b000};
    vecs[6] = '{1'b1, 4'h8,  4'd1,  4'b0111, 1'b1, 1'b1, 3'b001};
    vecs[7] = '{1'b1, 4'd0,  4'd0,  4'b0000, 1'b1, 1'b0, 3'b010};
    vecs[8] = '{1'b0, 4'h8,  4'h8,  4'b0000, 1'b1, 1'b1, 3'b000};

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    #12;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_s",    int'(bus.s),    0);
    check("reset_flags", int'({bus.cout, bus.ovf, cmp_now()}), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, done_cyc, busy_cyc);
      check($sformatf("v%0d_done_cycle", i), done_cyc, 5);
      check($sformatf("v%0d_busy_cycles", i), busy_cyc, 4);
      check($sformatf("v%0d_s", i),    int'(bus.s),    int'(vecs[i].s));
      check($sformatf("v%0d_cout", i), int'(bus.cout), int'(vecs[i].cout));
      check($sformatf("v%0d_ovf", i),  int'(bus.ovf),  int'(vecs[i].ovf));
      check($sformatf("v%0d_cmp", i),  int'(cmp_now()), int'(vecs[i].cmp));
      @(negedge clk);
      check($sformatf("v%0d_done_width", i), int'(bus.done), 0);
      check($sformatf("v%0d_s_hold", i), int'(bus.s), int'(vecs[i].s));
    end

    // Load a nonzero result, then abort a following operation with reset mid-RUN.
    run_op(1'b1, 4'd5, 4'hF, done_cyc, busy_cyc);
    @(negedge clk);
    bus.op    = 1'b0;
    bus.a     = 4'd3;
    bus.b     = 4'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_s",    int'(bus.s),    0);
    check("abort_flags", int'({bus.cout, bus.ovf, cmp_now()}), 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    run_op(1'b1, 4'd7, 4'h8, done_cyc, busy_cyc);
    check("post_reset_done_cycle", done_cyc, 5);
    check("post_reset_s", int'(bus.s), 15);
    check("post_reset_cmp", int'(cmp_now()), 3'b100);
    @(negedge clk);

    // Start held high: operands change mid-RUN, back-to-back ops every 6 cycles.
    bus.op    = 1'b1;
    bus.a     = 4'd5;
    bus.b     = 4'hF;
    bus.start = 1'b1;
    first_done  = 0;
    second_done = 0;
    prev_done   = 0;
    double_done = 0;
    s_first  = '0;
    s_second = '1;
    c_first  = '0;
    c_second = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.a = 4'd2;
      bus.b = 4'd2;
      if (bus.done && prev_done != 0) double_done++;
      prev_done = int'(bus.done);
      if (bus.done && first_done == 0) begin
        first_done = k;
        s_first    = bus.s;
        c_first    = cmp_now();
      end else if (bus.done && second_done == 0) begin
        second_done = k;
        s_second    = bus.s;
        c_second    = cmp_now();
      end
    end
    bus.start = 1'b0;
    check("held_first_done",  first_done,  5);
    check("held_second_done", second_done, 11);
    check("held_first_s",     int'(s_first),  4'b0110);
    check("held_first_cmp",   int'(c_first),  3'b100);
    check("held_second_s",    int'(s_second), 4'b0000);
    check("held_second_cmp",  int'(c_second), 3'b010);
    check("held_done_width",  double_done, 0);

    repeat (8) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_addsub_cmp.md
SERIAL_ADDSUB_CMP -- requirements
Module: serial_addsub_cmp

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Op  input  1  0 = add (A+B), 1 = subtract/compare (A-B).
REQ-006 A  input  WIDTH  two's-complement operand A; captured on the Start edge.
REQ-007 B  input  WIDTH  two's-complement operand B; captured on the Start edge.
REQ-008 Busy  output  1  high while the operation is being computed (RUN state).
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 S  output  WIDTH  sum/difference result.
REQ-011 Cout  output  1  carry out of the MSB.
REQ-012 Ovf  output  1  signed overflow.
REQ-013 CMP1  output  1  A > B (signed); valid after Op=1.
REQ-014 CMP2  output  1  A == B; valid after Op=1.
REQ-015 CMP3  output  1  A < B (signed); valid after Op=1.

Function
REQ-016 FSM states: IDLE, RUN, DONE; no other reachable states.
REQ-017 IDLE with Start=1 at a rising edge: capture A, B, Op; load carry = Op; clear bit counter; go to RUN.
REQ-018 IDLE with Start=0: stay in IDLE, outputs hold.
REQ-019 RUN: exactly one full-adder cell is used per cycle, processing bit i = counter, LSB first; operand bit b = B[i] XOR Op.
REQ-020 RUN, each edge: sum bit written into the result shift register; carry register updated with the full-adder carry; counter incremented.
REQ-021 RUN exits to DONE on the edge that processes bit WIDTH-1, so RUN lasts exactly WIDTH cycles.
REQ-022 Entering DONE: S, Cout, Ovf and the CMP flags update together and are visible in the same cycle that Done = 1.
REQ-023 DONE returns to IDLE unconditionally after one cycle; Done is high for exactly that one cycle.
REQ-024 Latency: Done is asserted WIDTH+1 cycles after the Start sampling edge; minimum initiation interval is WIDTH+2 cycles.
REQ-025 Busy = 1 only in RUN.
REQ-026 Start is ignored in RUN and DONE; captured operands and operation are unaffected by input changes after capture.
REQ-027 Ovf = carry into the MSB XOR carry out of the MSB.
REQ-028 Op=1 flags: Z = (S == 0); N = S[WIDTH-1]; CMP3 = N XOR Ovf; CMP2 = Z; CMP1 = NOT CMP3 AND NOT Z. Exactly one flag is high.
REQ-029 Op=0 completion: CMP1, CMP2 and CMP3 are all cleared to 0.
REQ-030 Result outputs hold their values from the last completion until the next DONE entry or reset.
REQ-031 Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-032 Reset=1 forces IDLE immediately, independent of Clk: S=0, Cout=0, Ovf=0, CMP1..3=0, Busy=0, Done=0; internal registers and counter are cleared.
REQ-033 Reset asserted during RUN or DONE aborts the operation; no Done pulse is produced for the aborted operation.
REQ-034 After Reset deasserts, the first Start in IDLE is accepted normally.

Verification (WIDTH=4)
REQ-035 Reset pulse mid-RUN -> Busy and Done drop immediately, all outputs 0, no Done pulse afterwards until a new Start.
REQ-036 Op=0, A=3, B=5 -> S=1000, Cout=0, Ovf=1, CMP=000; Done exactly 5 cycles after the Start edge, Busy high for 4 cycles.
REQ-037 Op=1, A=-8 (1000), B=-5 (1011) -> S=1101, Cout=0, Ovf=0, CMP3=1 only.
REQ-038 Op=1, A=5, B=-1 -> S=0110, Cout=0, Ovf=0, CMP1=1 only; then Op=1, A=2, B=2 -> S=0000, Cout=1, CMP2=1 only.
REQ-039 Op=1, A=7, B=-8 -> S=1111, Ovf=1, CMP1=1 only (overflow-corrected compare).
REQ-040 Start held high, with A/B toggled during RUN -> single operation on the captured values; next operation begins on the IDLE edge after DONE; Done pulses never span 2 cycles.
